mem_req_controller: RTL and testbench
=====================================

Name: mem_req_controller

Overview:
- Sits directly downstream of the core's memory port and services its read and write requests against a single-port synchronous word RAM.
- Turns one-cycle request pulses into RAM enable/write strobes, waits a configurable RAM read latency, and returns a one-cycle acknowledge with the read data.
- Reports range, alignment and protocol errors as sticky flags.

Parameters:
ADDR_W, 10, RAM word-address width
DEPTH, 1024, number of 32-bit words implemented; must be <= 2**ADDR_W
READ_LATENCY, 1, cycles from memEn edge to valid memRData (1..4)
MISS_DATA, 32'hDEADBEEF, data returned for out-of-range reads

Ports:
clk  input  1  clock
reset  input  1  asynchronous, active-high reset
cpuAddress  input  32  byte address from core
cpuWriteData  input  32  write data from core
cpuReadReq  input  1  read request pulse
cpuWriteReq  input  1  write request pulse
cpuReadData  output  32  read data; valid while cpuReadAck=1, then held
cpuReadAck  output  1  one-cycle read acknowledge
cpuWriteAck  output  1  one-cycle write acknowledge
memEn  output  1  RAM enable
memWe  output  1  RAM write enable
memAddr  output  ADDR_W  RAM word address (cpuAddress[ADDR_W+1:2])
memWData  output  32  RAM write data
memRData  input  32  RAM read data
errFlags  output  3  sticky flags: [0] range, [1] align, [2] protocol

Behaviour:
- Reset: all outputs 0 and state IDLE. A reset asserted mid-transaction aborts it with no ack, and any in-flight memRData is discarded.
- FSM states: IDLE, RD_WAIT, RD_ACK, WR_ACK.
- All outputs are registered.
- IDLE, request capture:
  - On the clk edge where cpuReadReq or cpuWriteReq = 1, latch cpuAddress and cpuWriteData.
  - Requests are sampled only in IDLE; the core deasserts the request one cycle later, and the captured values are used from then on.
- Read path:
  - Edge E0 (read request seen): memEn=1, memWe=0, memAddr driven for one cycle; go to RD_WAIT with counter = READ_LATENCY.
  - RD_WAIT: the counter decrements each edge. At zero, register cpuReadData <= memRData, pulse cpuReadAck, and pass through RD_ACK back to IDLE.
  - cpuReadAck is high in the cycle following edge E0+READ_LATENCY+1, i.e. ack is visible READ_LATENCY+1 cycles after the request edge. Default latency: ack appears 2 cycles after the request.
- Write path:
  - Edge E0: memEn=1, memWe=1, memAddr and memWData driven for exactly one cycle; go to WR_ACK.
  - Edge E1: cpuWriteAck=1 for one cycle; return to IDLE.
- Ack rules:
  - Acks are exactly one cycle wide and never both high together.
  - cpuReadData is stable from the ack cycle until the next read ack.
  - A new request is accepted no earlier than the cycle the ack is visible (back-to-back allowed).
- Range: word index >= DEPTH (computed from the full cpuAddress[31:2], not the truncated memAddr).
  - Read: no memEn; data is MISS_DATA with the same ack latency.
  - Write: no memEn/memWe; ack still given.
  - Sets errFlags[0].
- Alignment: cpuAddress[1:0] != 0 sets errFlags[1]; access proceeds word-aligned (low bits ignored).
- Protocol:
  - A request seen while not IDLE is dropped (no ack) and sets errFlags[2].
  - cpuReadReq and cpuWriteReq high together: the write is performed, the read is ignored, and errFlags[2] is set.
- errFlags clear only on reset.
- Address arithmetic is unsigned; no wrap. Addresses >= 4*DEPTH are out of range.

Optional Feature:
- Macro MEM_REQ_MMIO_OUT_EN.
- Defined:
  - Adds output mmioOut[31:0] (reset 0).
  - A write to byte address 32'hFFFFFFF0 loads mmioOut instead of touching RAM; ack on the same timing, no range error.
  - A read of that address returns mmioOut with normal read latency.
- Undefined: port absent; the address is treated as out of range like any other.

Decomposition:
- Shared package mem_req_pkg holds:
  - FSM state enum
  - error-bit index constants (ERR_RANGE=0, ERR_ALIGN=1, ERR_PROTO=2)
  - MISS_DATA default
  - MMIO address constant
- One natural sub-module: mem_req_latency_ctr, a loadable down-counter with a done pulse used in RD_WAIT.
- FSM, capture registers and error logic stay in the top module.

Test Plan:
- Write 32'h12345678 to addr 0x10, then read 0x10 (READ_LATENCY=1) -> memWe pulse with memAddr=4; cpuWriteAck one cycle after the request edge; cpuReadAck 2 cycles after the read request with cpuReadData=32'h12345678.
- READ_LATENCY=3 read of preloaded word 0x0 = 32'hCAFEF00D -> ack exactly 4 cycles after the request; data correct and held after the ack drops.
- Read addr 4*DEPTH (0x1000) -> no memEn, cpuReadData=32'hDEADBEEF, ack at normal latency, errFlags=3'b001.
- Read/write to 0x13 -> accesses word 4; errFlags[1]=1. Simultaneous read+write req to 0x20 with data 5 -> write performed, write ack only, errFlags[2]=1.
- Reset asserted during RD_WAIT -> no ack, outputs and errFlags 0; the next read completes normally.
- With MEM_REQ_MMIO_OUT_EN: write 32'hA5 to 0xFFFFFFF0 -> mmioOut=32'hA5, RAM untouched, errFlags=0; read-back returns 32'hA5.

Source files
------------

// File: rtl/mem_req_pkg.sv
// Shared types and constants for the memory request controller.
package mem_req_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRdWait,
    StRdAck,
    StWrAck
  } stateT;

  localparam int unsigned ERR_RANGE = 0;
  localparam int unsigned ERR_ALIGN = 1;
  localparam int unsigned ERR_PROTO = 2;

  localparam logic [31:0] MISS_DATA_DEFAULT = 32'hDEADBEEF;
  localparam logic [31:0] MMIO_ADDR         = 32'hFFFFFFF0;

  function automatic logic isMmioAddr(input logic [31:0] byteAddr);
    return byteAddr == MMIO_ADDR;
  endfunction

endpackage

// File: rtl/mem_req_if.sv
// Core-side request/acknowledge bus of the memory request controller.
interface mem_req_if;
  import mem_req_pkg::*;

  logic [31:0] cpuAddress;
  logic [31:0] cpuWriteData;
  logic        cpuReadReq;
  logic        cpuWriteReq;
  logic [31:0] cpuReadData;
  logic        cpuReadAck;
  logic        cpuWriteAck;

  modport master (
    output cpuAddress, cpuWriteData, cpuReadReq, cpuWriteReq,
    input  cpuReadData, cpuReadAck, cpuWriteAck
  );

  modport slave (
    input  cpuAddress, cpuWriteData, cpuReadReq, cpuWriteReq,
    output cpuReadData, cpuReadAck, cpuWriteAck
  );

endinterface

// File: rtl/mem_req_latency_ctr.sv
// Loadable down-counter; done pulses on the edge where the count reaches zero.
module mem_req_latency_ctr #(
  parameter int unsigned WIDTH = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] loadValue,
  output logic             done
);

  logic [WIDTH-1:0] countQ;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      countQ <= '0;
    end else if (load) begin
      countQ <= loadValue;
    end else if (countQ != '0) begin
      countQ <= countQ - 1'b1;
    end
  end

  assign done = (countQ == WIDTH'(1));

endmodule

// File: rtl/mem_req_controller.sv
// Services core read/write requests against a synchronous word RAM.
// Optional MMIO output register enabled by MEM_REQ_MMIO_OUT_EN.
module mem_req_controller
  import mem_req_pkg::*;
#(
  parameter int unsigned ADDR_W       = 10,
  parameter int unsigned DEPTH        = 1024,
  parameter int unsigned READ_LATENCY = 1,
  parameter logic [31:0] MISS_DATA    = MISS_DATA_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  mem_req_if.slave          cpu,
  output logic              memEn,
  output logic              memWe,
  output logic [ADDR_W-1:0] memAddr,
  output logic [31:0]       memWData,
  input  logic [31:0]       memRData,
  output logic [2:0]        errFlags
`ifdef MEM_REQ_MMIO_OUT_EN
  ,
  output logic [31:0]       mmioOut
`endif
);

  stateT             stateQ, stateD;
  logic              missQ, missD;
  logic              mmioHitQ, mmioHitD;
  logic              memEnD, memWeD, readAckD, writeAckD, ctrLoad, ctrDone;
  logic [ADDR_W-1:0] memAddrD;
  logic [31:0]       memWDataD, readDataD, mmioValue;
  logic [2:0]        errD;
  logic              reqAny, reqMmio, reqInRange;

  function automatic logic inRange(input logic [29:0] wordIdx);
    return {2'b00, wordIdx} < 32'(DEPTH);
  endfunction

  assign reqAny     = cpu.cpuReadReq | cpu.cpuWriteReq;
  assign reqInRange = inRange(cpu.cpuAddress[31:2]);

`ifdef MEM_REQ_MMIO_OUT_EN
  logic [31:0] mmioQ;

  assign reqMmio = isMmioAddr(cpu.cpuAddress);

  // memWData doubles as the captured write data for the MMIO load.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mmioQ <= '0;
    end else if (stateQ == StWrAck && mmioHitQ) begin
      mmioQ <= memWData;
    end
  end

  assign mmioOut   = mmioQ;
  assign mmioValue = mmioQ;
`else
  assign reqMmio   = 1'b0;
  assign mmioValue = '0;
`endif

  mem_req_latency_ctr #(
    .WIDTH(3)
  ) u_latency_ctr (
    .clk      (clk),
    .reset    (reset),
    .load     (ctrLoad),
    .loadValue(3'(READ_LATENCY)),
    .done     (ctrDone)
  );

  always_comb begin
    stateD    = stateQ;
    missD     = missQ;
    mmioHitD  = mmioHitQ;
    memEnD    = 1'b0;
    memWeD    = 1'b0;
    memAddrD  = memAddr;
    memWDataD = memWData;
    readAckD  = 1'b0;
    writeAckD = 1'b0;
    readDataD = cpu.cpuReadData;
    errD      = errFlags;
    ctrLoad   = 1'b0;

    if (reqAny && stateQ != StIdle) errD[ERR_PROTO] = 1'b1;

    unique case (stateQ)
      StIdle: begin
        if (reqAny) begin
          memAddrD  = cpu.cpuAddress[ADDR_W+1:2];
          memEnD    = reqInRange && !reqMmio;
          missD     = !reqInRange && !reqMmio;
          mmioHitD  = reqMmio;
          memWDataD = cpu.cpuWriteData;
          if (cpu.cpuReadReq && cpu.cpuWriteReq) errD[ERR_PROTO] = 1'b1;
          if (cpu.cpuAddress[1:0] != 2'b00) errD[ERR_ALIGN] = 1'b1;
          if (!reqInRange && !reqMmio) errD[ERR_RANGE] = 1'b1;
          if (cpu.cpuWriteReq) begin
            memWeD = reqInRange && !reqMmio;
            stateD = StWrAck;
          end else begin
            ctrLoad = 1'b1;
            stateD  = StRdWait;
          end
        end
      end
      StRdWait: begin
        if (ctrDone) stateD = StRdAck;
      end
      StRdAck: begin
        readAckD  = 1'b1;
        readDataD = mmioHitQ ? mmioValue : (missQ ? MISS_DATA : memRData);
        stateD    = StIdle;
      end
      StWrAck: begin
        writeAckD = 1'b1;
        stateD    = StIdle;
      end
      default: stateD = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stateQ          <= StIdle;
      missQ           <= 1'b0;
      mmioHitQ        <= 1'b0;
      memEn           <= 1'b0;
      memWe           <= 1'b0;
      memAddr         <= '0;
      memWData        <= '0;
      cpu.cpuReadAck  <= 1'b0;
      cpu.cpuWriteAck <= 1'b0;
      cpu.cpuReadData <= '0;
      errFlags        <= '0;
    end else begin
      stateQ          <= stateD;
      missQ           <= missD;
      mmioHitQ        <= mmioHitD;
      memEn           <= memEnD;
      memWe           <= memWeD;
      memAddr         <= memAddrD;
      memWData        <= memWDataD;
      cpu.cpuReadAck  <= readAckD;
      cpu.cpuWriteAck <= writeAckD;
      cpu.cpuReadData <= readDataD;
      errFlags        <= errD;
    end
  end

endmodule

// File: tb/tb_mem_req_controller.sv
// Scoreboard bench: dut1 at READ_LATENCY=1, dut2 at READ_LATENCY=3.
module tb_mem_req_controller;
  import mem_req_pkg::*;

  localparam int L1 = 1;
  localparam int L2 = 3;

  typedef struct {
    bit          isRead;
    logic [31:0] data;
    int          ackCyc;
  } expT;

  logic clk = 1'b0;
  logic reset1, reset2;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int nChecks = 0;
  int nFails  = 0;

  expT sb1[$];
  expT sb2[$];
  logic [31:0] sh1 [1024];
  logic [31:0] expMmio = '0;

  mem_req_if bus1 ();
  mem_req_if bus2 ();

  logic        memEn1, memWe1, memEn2, memWe2;
  logic [9:0]  memAddr1, memAddr2;
  logic [31:0] memWData1, memWData2, memRData1, memRData2;
  logic [2:0]  err1, err2;
`ifdef MEM_REQ_MMIO_OUT_EN
  logic [31:0] mmio1, mmio2;
`endif

  mem_req_controller #(.READ_LATENCY(L1)) dut1 (
    .clk(clk), .reset(reset1), .cpu(bus1),
    .memEn(memEn1), .memWe(memWe1), .memAddr(memAddr1), .memWData(memWData1),
    .memRData(memRData1), .errFlags(err1)
`ifdef MEM_REQ_MMIO_OUT_EN
    , .mmioOut(mmio1)
`endif
  );

  mem_req_controller #(.READ_LATENCY(L2)) dut2 (
    .clk(clk), .reset(reset2), .cpu(bus2),
    .memEn(memEn2), .memWe(memWe2), .memAddr(memAddr2), .memWData(memWData2),
    .memRData(memRData2), .errFlags(err2)
`ifdef MEM_REQ_MMIO_OUT_EN
    , .mmioOut(mmio2)
`endif
  );

  // RAM models: read data is valid for exactly one cycle after the latency.
  logic [31:0] ram1 [1024];
  logic [31:0] rp1 = '0;
  always @(posedge clk) begin
    rp1 <= (memEn1 && !memWe1) ? ram1[memAddr1] : 32'h0;
    if (memEn1 && memWe1) ram1[memAddr1] <= memWData1;
  end
  assign memRData1 = rp1;

  logic [31:0] ram2 [1024];
  logic [31:0] rp2 [3];
  initial ram2[0] = 32'hCAFEF00D;
  always @(posedge clk) begin
    rp2[0] <= (memEn2 && !memWe2) ? ram2[memAddr2] : 32'h0;
    rp2[1] <= rp2[0];
    rp2[2] <= rp2[1];
  end
  assign memRData2 = rp2[2];

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nChecks++;
    if (obs !== exp) begin
      nFails++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] expRead(input logic [31:0] a);
    if (a == MMIO_ADDR) begin
`ifdef MEM_REQ_MMIO_OUT_EN
      return expMmio;
`else
      return 32'hDEADBEEF;
`endif
    end
    if (a[31:2] >= 30'd1024) return 32'hDEADBEEF;
    return sh1[a[11:2]];
  endfunction

  // Drives one request cycle on dut1; returns #1 after the capturing edge.
  task automatic issue(input bit rd, input bit wr, input logic [31:0] addr,
                       input logic [31:0] data, input bit track);
    expT e;
    @(posedge clk); #1;
    bus1.cpuReadReq   = rd;
    bus1.cpuWriteReq  = wr;
    bus1.cpuAddress   = addr;
    bus1.cpuWriteData = data;
    if (track) begin
      e.isRead = !wr;
      e.ackCyc = cyc + 1 + (wr ? 1 : L1 + 1);
      e.data   = wr ? data : expRead(addr);
      if (wr) begin
        if (addr == MMIO_ADDR) begin
`ifdef MEM_REQ_MMIO_OUT_EN
          expMmio = data;
`endif
        end else if (addr[31:2] < 30'd1024) begin
          sh1[addr[11:2]] = data;
        end
      end
      sb1.push_back(e);
    end
    @(posedge clk); #1;
    bus1.cpuReadReq  = 1'b0;
    bus1.cpuWriteReq = 1'b0;
  endtask

  task automatic waitDrain(input bit sel);
    int n = 0;
    while ((sel ? sb2.size() : sb1.size()) != 0 && n < 30) begin
      @(negedge clk); #1;
      n++;
    end
    checkVal(sel ? "drain2" : "drain1", sel ? sb2.size() : sb1.size(), 0);
  endtask

  always @(negedge clk) begin
    expT e;
    if (!reset1 && (bus1.cpuReadAck || bus1.cpuWriteAck)) begin
      checkVal("ack_excl1", 32'(bus1.cpuReadAck & bus1.cpuWriteAck), 0);
      if (sb1.size() == 0) begin
        checkVal("unexp_ack1", 32'(bus1.cpuReadAck | bus1.cpuWriteAck), 0);
      end else begin
        e = sb1.pop_front();
        checkVal("ack_kind1", 32'(bus1.cpuReadAck), 32'(e.isRead));
        checkVal("ack_cyc1", cyc, e.ackCyc);
        if (e.isRead) checkVal("rdata1", bus1.cpuReadData, e.data);
      end
    end
  end

  always @(negedge clk) begin
    expT e;
    if (!reset2 && (bus2.cpuReadAck || bus2.cpuWriteAck)) begin
      if (sb2.size() == 0) begin
        checkVal("unexp_ack2", 32'(bus2.cpuReadAck | bus2.cpuWriteAck), 0);
      end else begin
        e = sb2.pop_front();
        checkVal("ack_kind2", 32'(bus2.cpuReadAck), 32'(e.isRead));
        checkVal("ack_cyc2", cyc, e.ackCyc);
        checkVal("rdata2", bus2.cpuReadData, e.data);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    expT e;
    bus1.cpuReadReq = 0; bus1.cpuWriteReq = 0; bus1.cpuAddress = 0; bus1.cpuWriteData = 0;
    bus2.cpuReadReq = 0; bus2.cpuWriteReq = 0; bus2.cpuAddress = 0; bus2.cpuWriteData = 0;
    reset1 = 1'b1;
    reset2 = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checkVal("rst_rdata", bus1.cpuReadData, 0);
    checkVal("rst_acks", {bus1.cpuReadAck, bus1.cpuWriteAck}, 0);
    checkVal("rst_mem", {memEn1, memWe1, memAddr1}, 0);
    checkVal("rst_wdata", memWData1, 0);
    checkVal("rst_wdata2", memWData2, 0);
    checkVal("rst_err", {err2, err1}, 0);
`ifdef MEM_REQ_MMIO_OUT_EN
    checkVal("rst_mmio", mmio1 | mmio2, 0);
`endif
    reset1 = 1'b0;
    reset2 = 1'b0;

    // Write then read back at 0x10
    issue(0, 1, 32'h10, 32'h12345678, 1);
    checkVal("wr_en", {memEn1, memWe1}, 2'b11);
    checkVal("wr_addr", memAddr1, 4);
    checkVal("wr_wdata", memWData1, 32'h12345678);
    @(posedge clk); #1;
    checkVal("wr_en_pulse", {memEn1, memWe1}, 0);
    waitDrain(0);
    issue(1, 0, 32'h10, 0, 1);
    checkVal("rd_en", {memEn1, memWe1}, 2'b10);
    checkVal("rd_addr", memAddr1, 4);
    waitDrain(0);
    checkVal("err_clean", err1, 3'b000);

    // Out-of-range read
    issue(1, 0, 32'h1000, 0, 1);
    checkVal("oor_en", memEn1, 0);
    waitDrain(0);
    checkVal("oor_err", err1, 3'b001);

    // Misaligned write and read
    issue(0, 1, 32'h13, 32'h77, 1);
    checkVal("al_addr", memAddr1, 4);
    waitDrain(0);
    issue(1, 0, 32'h13, 0, 1);
    waitDrain(0);
    checkVal("al_err", err1, 3'b011);

    // Simultaneous read and write: write wins
    issue(1, 1, 32'h20, 32'h5, 1);
    checkVal("both_we", {memEn1, memWe1}, 2'b11);
    checkVal("both_addr", memAddr1, 8);
    waitDrain(0);
    checkVal("both_err", err1, 3'b111);
    issue(1, 0, 32'h20, 0, 1);
    waitDrain(0);

    // Reset during RD_WAIT aborts the read
    issue(1, 0, 32'h10, 0, 1);
    reset1 = 1'b1;
    sb1.delete();
    #1;
    checkVal("mid_rst_out", {bus1.cpuReadAck, bus1.cpuWriteAck, memEn1, err1}, 0);
    checkVal("mid_rst_rdata", bus1.cpuReadData, 0);
    repeat (2) @(posedge clk);
    #1;
    reset1 = 1'b0;
    repeat (3) @(negedge clk);
    checkVal("mid_rst_err", err1, 0);
    issue(1, 0, 32'h10, 0, 1);
    waitDrain(0);

    // MMIO write and read-back
    issue(0, 1, MMIO_ADDR, 32'hA5, 1);
    checkVal("mmio_en", {memEn1, memWe1}, 0);
    waitDrain(0);
`ifdef MEM_REQ_MMIO_OUT_EN
    checkVal("mmio_out", mmio1, 32'hA5);
    checkVal("mmio_err", err1, 3'b000);
`else
    checkVal("mmio_err", err1, 3'b001);
`endif
    issue(1, 0, MMIO_ADDR, 0, 1);
    waitDrain(0);

    // Request while busy is dropped
    issue(1, 0, 32'h10, 0, 1);
    issue(1, 0, 32'h20, 0, 0);
    waitDrain(0);
    repeat (3) @(negedge clk);
`ifdef MEM_REQ_MMIO_OUT_EN
    checkVal("proto_err", err1, 3'b100);
`else
    checkVal("proto_err", err1, 3'b101);
`endif

    // READ_LATENCY=3 read of preloaded word 0
    @(posedge clk); #1;
    bus2.cpuAddress = 32'h0;
    bus2.cpuReadReq = 1'b1;
    e.isRead = 1'b1;
    e.data   = 32'hCAFEF00D;
    e.ackCyc = cyc + 1 + L2 + 1;
    sb2.push_back(e);
    @(posedge clk); #1;
    bus2.cpuReadReq = 1'b0;
    checkVal("l3_en", {memEn2, memWe2}, 2'b10);
    waitDrain(1);
    @(posedge clk); #1;
    checkVal("l3_ack_drop", bus2.cpuReadAck, 0);
    checkVal("l3_hold", bus2.cpuReadData, 32'hCAFEF00D);

    repeat (4) @(negedge clk);
    checkVal("sb_empty", sb1.size() + sb2.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
